// File: rtl/l1_pkg.sv
// Shared L1 definitions: refill FSM states, default geometry and address slicing helpers.
// Pure declarations; no latency or backpressure of its own.
package l1_pkg;

   localparam int L1_WORD_SIZE  = 32;
   localparam int L1_TAG_SIZE   = 2;
   localparam int L1_INDEX_SIZE = 4;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      FILL,
      ERR
   } state_t;

   function automatic logic [L1_TAG_SIZE-1:0] get_tag(input logic [L1_WORD_SIZE-1:0] addr);
      return addr[L1_WORD_SIZE-1 -: L1_TAG_SIZE];
   endfunction

   function automatic logic [L1_INDEX_SIZE-1:0] get_index(input logic [L1_WORD_SIZE-1:0] addr);
      return addr[L1_WORD_SIZE-L1_TAG_SIZE-1 -: L1_INDEX_SIZE];
   endfunction

endpackage

// File: rtl/l1_timeout_ctr.sv
// Response timeout counter: cleared on request handshake, counts while enabled, flags LIMIT-1.
// expired is combinational from the count register; no backpressure.
module l1_timeout_ctr #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   assign expired = (cnt == CW'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/l1_refill_ctrl.sv
// Single-outstanding L1 miss refill: fetch one word, then pulse fill/resp (or err on timeout).
// Best case miss->fill is 3 cycles; misses are only taken in IDLE, request held until mem_req_ready.
module l1_refill_ctrl
   import l1_pkg::*;
#(
   parameter int WORD_SIZE  = L1_WORD_SIZE,
   parameter int TAG_SIZE   = L1_TAG_SIZE,
   parameter int INDEX_SIZE = L1_INDEX_SIZE,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  miss_valid,
   input  logic [WORD_SIZE-1:0]  miss_addr,
   output logic                  miss_ready,
   output logic                  mem_req_valid,
   output logic [WORD_SIZE-1:0]  mem_req_addr,
   input  logic                  mem_req_ready,
   input  logic                  mem_resp_valid,
   input  logic [WORD_SIZE-1:0]  mem_resp_data,
   output logic                  fill_valid,
   output logic [INDEX_SIZE-1:0] fill_index,
   output logic [TAG_SIZE-1:0]   fill_tag,
   output logic [WORD_SIZE-1:0]  fill_data,
   output logic                  resp_valid,
   output logic [WORD_SIZE-1:0]  resp_data,
   output logic                  err,
   output logic                  busy,
   output logic [15:0]           miss_count
);

   localparam int TAG_LSB = WORD_SIZE - TAG_SIZE;

   state_t state;
   logic   to_clr;
   logic   to_en;
   logic   to_expired;

   assign miss_ready = (state == IDLE);
   assign busy       = (state != IDLE);
   assign to_clr     = (state == REQ) && mem_req_ready;
   assign to_en      = (state == WAIT);

   l1_timeout_ctr #(
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (to_clr),
      .en      (to_en),
      .expired (to_expired)
   );

   // mem_req_addr doubles as the captured miss address for the whole transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         fill_valid    <= 1'b0;
         fill_index    <= '0;
         fill_tag      <= '0;
         fill_data     <= '0;
         resp_valid    <= 1'b0;
         resp_data     <= '0;
         err           <= 1'b0;
         miss_count    <= '0;
      end else begin
         fill_valid <= 1'b0;
         resp_valid <= 1'b0;
         err        <= 1'b0;
         case (state)
            IDLE: begin
               if (miss_valid) begin
                  mem_req_addr  <= miss_addr;
                  mem_req_valid <= 1'b1;
                  if (miss_count != 16'hFFFF) begin
                     miss_count <= miss_count + 16'd1;
                  end
                  state <= REQ;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  fill_valid <= 1'b1;
                  resp_valid <= 1'b1;
                  fill_data  <= mem_resp_data;
                  resp_data  <= mem_resp_data;
                  fill_tag   <= mem_req_addr[WORD_SIZE-1 -: TAG_SIZE];
                  fill_index <= mem_req_addr[TAG_LSB-1 -: INDEX_SIZE];
                  state      <= FILL;
               end else if (to_expired) begin
                  err   <= 1'b1;
                  state <= ERR;
               end
            end
            FILL:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Directed bench for l1_refill_ctrl: expected strobes are queued at issue and checked by a monitor.
module tb_l1_refill_ctrl;

   localparam int TO = 8;

   typedef struct packed {
      logic        is_err;
      logic [1:0]  tag;
      logic [3:0]  idx;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        miss_valid = 1'b0;
   logic [31:0] miss_addr = '0;
   logic        miss_ready;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready = 1'b0;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;
   logic        fill_valid;
   logic [3:0]  fill_index;
   logic [1:0]  fill_tag;
   logic [31:0] fill_data;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        err;
   logic        busy;
   logic [15:0] miss_count;

   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   l1_refill_ctrl #(
      .WORD_SIZE  (32),
      .TAG_SIZE   (2),
      .INDEX_SIZE (4),
      .TIMEOUT    (TO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .miss_valid     (miss_valid),
      .miss_addr      (miss_addr),
      .miss_ready     (miss_ready),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .fill_valid     (fill_valid),
      .fill_index     (fill_index),
      .fill_tag       (fill_tag),
      .fill_data      (fill_data),
      .resp_valid     (resp_valid),
      .resp_data      (resp_data),
      .err            (err),
      .busy           (busy),
      .miss_count     (miss_count)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_ctrl"}, {miss_ready, busy, mem_req_valid, fill_valid, resp_valid, err}, 6'b100000);
      chk({name, "_data"}, {mem_req_addr, fill_data, resp_data, fill_tag, fill_index, miss_count}, '0);
   endtask

   // resp_dly counts WAIT cycles before the response; negative or >= TO means no response in time.
   task automatic run_miss(input logic [31:0] addr, input logic [1:0] tag, input logic [3:0] idx,
                           input int rdy_dly, input int resp_dly, input logic [31:0] data);
      int n;
      bit timeout;
      n = 0;
      timeout = (resp_dly < 0) || (resp_dly >= TO);
      while (!miss_ready && n < 100) begin
         step();
         n++;
      end
      chk("miss_ready_before_accept", miss_ready, 1'b1);
      exp_q.push_back('{timeout, tag, idx, data});
      miss_valid = 1'b1;
      miss_addr  = addr;
      step();
      miss_valid = 1'b0;
      miss_addr  = '0;
      repeat (rdy_dly) begin
         chk("req_hold", {mem_req_valid, miss_ready, mem_req_addr}, {1'b1, 1'b0, addr});
         step();
      end
      chk("req_hold", {mem_req_valid, miss_ready, mem_req_addr}, {1'b1, 1'b0, addr});
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("req_dropped", {mem_req_valid, busy}, 2'b01);
      if (!timeout) begin
         repeat (resp_dly) step();
         mem_resp_valid = 1'b1;
         mem_resp_data  = data;
         step();
         mem_resp_valid = 1'b0;
         mem_resp_data  = '0;
         chk("fill_timing", {fill_valid, resp_valid, err}, 3'b110);
      end else begin
         repeat (TO) step();
         chk("err_timing", {fill_valid, resp_valid, err}, 3'b001);
      end
      step();
      chk("back_to_idle", {miss_ready, busy, fill_valid, resp_valid, err}, 5'b10000);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && (fill_valid || resp_valid || err)) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe fill=%b resp=%b err=%b", fill_valid, resp_valid, err);
         end else begin
            e = exp_q.pop_front();
            if (e.is_err) begin
               if ({fill_valid, resp_valid, err} !== 3'b001) begin
                  failures++;
                  $display("FAIL err_strobe fill=%b resp=%b err=%b expected 0 0 1",
                           fill_valid, resp_valid, err);
               end
            end else if ({fill_valid, resp_valid, err, fill_tag, fill_index, fill_data, resp_data} !==
                         {3'b110, e.tag, e.idx, e.data, e.data}) begin
               failures++;
               $display("FAIL fill_strobe fv=%b rv=%b err=%b tag=%h idx=%h fd=%h rd=%h expected tag=%h idx=%h data=%h",
                        fill_valid, resp_valid, err, fill_tag, fill_index, fill_data, resp_data,
                        e.tag, e.idx, e.data);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] exp_cnt;

      @(negedge clk);
      chk_reset("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      run_miss(32'h9000_0000, 2'b10, 4'h4, 0, 0, 32'hDEADBEEF);
      chk("miss_count_first", miss_count, 16'd1);

      run_miss(32'h5A5A_1234, 2'b01, 4'h6, 5, 2, 32'h1234_5678);
      chk("miss_count_second", miss_count, 16'd2);

      run_miss(32'h7000_0008, 2'b01, 4'hC, 1, -1, 32'h0);
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hBAD0_BAD0;
      step();
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      step();
      step();
      chk("late_resp_ignored", {busy, fill_valid, resp_valid, err, fill_data}, {4'b0000, 32'h1234_5678});
      chk("miss_count_timeout", miss_count, 16'd3);

      run_miss(32'hFC00_0000, 2'b11, 4'hF, 0, TO - 1, 32'hCAFE_F00D);

      miss_valid = 1'b1;
      miss_addr  = 32'h4400_0000;
      step();
      miss_valid    = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      chk_reset("reset_in_wait");
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_miss(32'h4400_0000, 2'b01, 4'h1, 0, 1, 32'hA5A5_5A5A);
      chk("miss_count_after_reset", miss_count, 16'd1);

      // Start near the saturation point.
      force dut.miss_count = 16'hFFFC;
      #1;
      release dut.miss_count;
      for (int i = 1; i <= 5; i++) begin
         run_miss(32'h8000_0000 + 32'(i * 4), 2'b10, 4'h0, 0, 0, 32'h1000_0000 + 32'(i));
         exp_cnt = (i < 3) ? 16'(16'hFFFC + i) : 16'hFFFF;
         chk("miss_count_sat", miss_count, exp_cnt);
      end

      step();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/l1_refill_ctrl.md
# l1_refill_ctrl

Miss-refill controller placed directly downstream of the direct-mapped L1. It accepts one read miss at a time from the L1 and issues a single-word fetch to main memory over a valid/ready request channel. On the memory response it emits a one-cycle fill write (valid, index, tag, data) back into the L1 and a matching data return to the requester. It also enforces a response timeout and keeps a saturating miss counter for debug.

## Interface
- WORD_SIZE, 32, address and data width
- TAG_SIZE, 2, tag bits taken from the top of the address
- INDEX_SIZE, 4, index bits directly below the tag
- TIMEOUT, 255, maximum WAIT cycles before abort; must be ≥1

- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- miss_valid  in  1  L1 reports a read miss
- miss_addr  in  WORD_SIZE  address of the missing word
- miss_ready  out  1  controller can accept a miss (high only in IDLE)
- mem_req_valid  out  1  fetch request to memory
- mem_req_addr  out  WORD_SIZE  fetch address, stable while mem_req_valid is high
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  memory data valid (single-cycle pulse)
- mem_resp_data  in  WORD_SIZE  returned word
- fill_valid  out  1  one-cycle L1 fill strobe
- fill_index  out  INDEX_SIZE  line to fill
- fill_tag  out  TAG_SIZE  tag to store
- fill_data  out  WORD_SIZE  data to store
- resp_valid  out  1  one-cycle data return to requester
- resp_data  out  WORD_SIZE  returned data
- err  out  1  one-cycle timeout pulse
- busy  out  1  high in any state other than IDLE
- miss_count  out  16  saturating count of accepted misses

## Operation
- All outputs are registered except miss_ready and busy, which decode the state register.
- Reset values: state IDLE, every output 0 except miss_ready=1. Captured address, data, timeout counter and miss_count all clear to 0.
- Address slicing:
  - tag = addr[WORD_SIZE-1 : WORD_SIZE-TAG_SIZE]
  - index = addr[WORD_SIZE-TAG_SIZE-1 : WORD_SIZE-TAG_SIZE-INDEX_SIZE]
- IDLE:
  - On miss_valid (miss_ready is high), capture miss_addr, increment miss_count (saturating at 16'hFFFF) and go to REQ.
  - miss_valid outside IDLE is ignored; the L1 must hold it until miss_ready.
- REQ:
  - mem_req_valid=1 and mem_req_addr=captured address, held until mem_req_ready.
  - On mem_req_ready go to WAIT and clear the timeout counter.
- WAIT:
  - Counter increments each cycle.
  - On mem_resp_valid, capture mem_resp_data and go to FILL.
  - Otherwise, when the counter equals TIMEOUT-1, go to ERR.
  - If mem_resp_valid and the timeout condition occur in the same cycle, the response wins.
- FILL:
  - fill_valid=1 and resp_valid=1 for exactly one cycle, with fill_index, fill_tag, fill_data and resp_data taken from the captured values.
  - Then go to IDLE.
- ERR:
  - err=1 for one cycle; fill_valid and resp_valid stay 0.
  - Then go to IDLE.
- mem_resp_valid in IDLE, REQ, FILL or ERR is dropped with no effect; a late response to an aborted request is discarded.
- fill_index, fill_tag, fill_data and resp_data hold their last values when not strobed.
- Counter width is $clog2(TIMEOUT+1); it never wraps, because it leaves WAIT first.

## Timing
- Cycle 0: miss accepted. Cycle 1: mem_req_valid high (REQ).
- Request handshake completes in the first REQ cycle in which mem_req_ready is high; WAIT starts the next cycle.
- A response in WAIT cycle n gives fill_valid/resp_valid in cycle n+1 and miss_ready high in cycle n+2.
- Best case: ready in cycle 1 and response in cycle 2 give fill in cycle 3.
- Timeout: err is asserted the cycle after WAIT has lasted TIMEOUT cycles.
- Back-to-back misses: a second miss is accepted no earlier than the cycle after FILL or ERR.
- Reset asserted mid-operation returns to IDLE asynchronously and clears all outputs immediately, including mem_req_valid. Memory must tolerate request withdrawal on reset.

## Structure
- Package l1_pkg holds:
  - the state enum (IDLE, REQ, WAIT, FILL, ERR);
  - default WORD_SIZE, TAG_SIZE and INDEX_SIZE constants, shared with the L1;
  - get_tag / get_index slicing functions.
- One sub-module: l1_timeout_ctr (clear, enable, parameterised limit, expired flag).

## Test plan
- Reset, then miss_addr=32'h9000_0000 with ready immediate and response 32'hDEADBEEF one cycle later:
  - fill_valid in cycle 3, fill_tag=2'b10, fill_index=4'h4, fill_data=resp_data=32'hDEADBEEF;
  - miss_count=1.
- mem_req_ready held low for 5 cycles:
  - mem_req_valid stays high with mem_req_addr stable;
  - miss_ready stays low;
  - completion after ready.
- TIMEOUT=8 with no response:
  - err pulses once, fill_valid never asserts, return to IDLE;
  - a response injected afterwards is ignored.
- Response in the same cycle as the timeout limit: FILL occurs and err stays 0.
- rst_n dropped during WAIT: all outputs 0 immediately; after release, a new miss completes normally with miss_count=1.
- 70000 back-to-back misses: miss_count saturates at 16'hFFFF.
